// File: rtl/modexp_ctrl.sv
// Modular exponentiation sequencer: drives an external Montgomery product unit
// through left-to-right square-and-multiply and returns a fully reduced M^E mod N.
module modexp_ctrl #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATAWIDTH-1:0] i_M,
    input  logic [DATAWIDTH-1:0] i_E,
    input  logic [DATAWIDTH-1:0] i_N,
    input  logic [DATAWIDTH-1:0] i_R2,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATAWIDTH-1:0] o_C,
    output logic                 mp_start,
    input  logic                 mp_ready,
    input  logic                 mp_valid,
    output logic [DATAWIDTH-1:0] mp_A,
    output logic [DATAWIDTH-1:0] mp_B,
    output logic [DATAWIDTH-1:0] mp_N,
    input  logic [DATAWIDTH-1:0] mp_U
);
    localparam int IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_REDUCE, S_DONE} state_t;
    typedef enum logic [2:0] {OP_MBAR, OP_XBAR, OP_SQR, OP_MUL, OP_POST} op_t;

    state_t               state_q;
    op_t                  op_q, op_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATAWIDTH-1:0] m_q, e_q, n_q, r2_q, x_q, mbar_q;
    logic [DATAWIDTH:0]   diff;

    assign o_ready  = (state_q == S_IDLE);
    assign mp_start = (state_q == S_ISSUE) && mp_ready;
    assign mp_N     = n_q;
    // Borrow out of the (DATAWIDTH+1)-bit subtract means X < N.
    assign diff     = {1'b0, x_q} - {1'b0, n_q};

    // Operands only change when op_q or the captured X/Mbar change, which
    // happens no earlier than the mp_valid edge, so they stay stable in flight.
    always_comb begin
        mp_A = '0;
        mp_B = '0;
        case (op_q)
            OP_MBAR: begin mp_A = m_q;    mp_B = r2_q; end
            OP_XBAR: begin mp_A = ONE;    mp_B = r2_q; end
            OP_SQR:  begin mp_A = x_q;    mp_B = x_q;  end
            OP_MUL:  begin mp_A = mbar_q; mp_B = x_q;  end
            OP_POST: begin mp_A = x_q;    mp_B = ONE;  end
            default: ;
        endcase
    end

    always_comb begin
        op_d  = op_q;
        idx_d = idx_q;
        case (op_q)
            OP_MBAR: op_d = OP_XBAR;
            OP_XBAR: begin
                op_d  = OP_SQR;
                idx_d = IW'(DATAWIDTH - 1);
            end
            OP_SQR: begin
                if (e_q[idx_q])
                    op_d = OP_MUL;
                else if (idx_q == '0)
                    op_d = OP_POST;
                else
                    idx_d = idx_q - 1'b1;
            end
            OP_MUL: begin
                if (idx_q == '0) begin
                    op_d = OP_POST;
                end else begin
                    op_d  = OP_SQR;
                    idx_d = idx_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MBAR;
            idx_q   <= '0;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            r2_q    <= '0;
            x_q     <= '0;
            mbar_q  <= '0;
            o_valid <= 1'b0;
            o_C     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (i_valid) begin
                    m_q     <= i_M;
                    e_q     <= i_E;
                    n_q     <= i_N;
                    r2_q    <= i_R2;
                    x_q     <= '0;
                    mbar_q  <= '0;
                    idx_q   <= '0;
                    op_q    <= OP_MBAR;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: if (mp_ready) state_q <= S_WAIT;
                S_WAIT: if (mp_valid) begin
                    if (op_q == OP_MBAR) mbar_q <= mp_U;
                    else                 x_q    <= mp_U;
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    op_q    <= op_d;
                    idx_q   <= idx_d;
                    state_q <= (op_q == OP_POST) ? S_REDUCE : S_ISSUE;
                end
                S_REDUCE: begin
                    o_C     <= diff[DATAWIDTH] ? x_q : diff[DATAWIDTH-1:0];
                    o_valid <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: if (i_ready) begin
                    o_valid <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural Montgomery product stub with random latency
// and random [0,2N) representative, checked against a plain modpow model.
module tb_modexp_ctrl;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0, i_ready = 1'b0;
    logic [DW-1:0] i_M = '0, i_E = '0, i_N = '0, i_R2 = '0;
    logic          o_ready, o_valid, mp_start, mp_ready;
    logic          mp_valid;
    logic [DW-1:0] o_C, mp_A, mp_B, mp_N, mp_U;

    int n_asrt = 0;
    int n_fail = 0;

    modexp_ctrl #(.DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_M(i_M), .i_E(i_E), .i_N(i_N), .i_R2(i_R2),
        .o_valid(o_valid), .i_ready(i_ready), .o_C(o_C),
        .mp_start(mp_start), .mp_ready(mp_ready), .mp_valid(mp_valid),
        .mp_A(mp_A), .mp_B(mp_B), .mp_N(mp_N), .mp_U(mp_U)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A*B*R^-1 mod N with R = 2^DW, by brute-force inverse of R.
    function automatic longint mont(longint a, longint b, longint n);
        longint rinv = 0;
        if (n <= 1) return 0;
        for (longint r = 1; r < n; r++)
            if (((longint'(1) << DW) * r) % n == 1) rinv = r;
        return (((a * b) % n) * rinv) % n;
    endfunction

    function automatic longint refpow(longint m, longint e, longint n);
        longint r = 1 % n;
        longint b = m % n;
        for (int i = 0; i < DW; i++) begin
            if (((e >> i) & 1) == 1) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r;
    endfunction

    // Product unit stub
    logic          busy_s = 1'b0, hold_rdy = 1'b0;
    int            cnt_s = 0;
    int            starts = 0;
    logic [DW-1:0] res_s = '0, sa = '0, sb = '0, sn = '0;

    assign mp_ready = !busy_s && !hold_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_s   <= 1'b0;
            cnt_s    <= 0;
            mp_valid <= 1'b0;
            mp_U     <= '0;
        end else begin
            mp_valid <= 1'b0;
            if (busy_s) begin
                if (cnt_s == 0) begin
                    busy_s   <= 1'b0;
                    mp_valid <= 1'b1;
                    mp_U     <= res_s;
                end else begin
                    cnt_s <= cnt_s - 1;
                end
            end else if (mp_start) begin
                busy_s <= 1'b1;
                cnt_s  <= $urandom_range(0, 3);
                res_s  <= DW'(mont(mp_A, mp_B, mp_N) + (($urandom_range(0, 1) == 1) ? longint'(mp_N) : 0));
                sa     <= mp_A;
                sb     <= mp_B;
                sn     <= mp_N;
                starts <= starts + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy_s || mp_valid) begin
                chk("mp_A_stable", mp_A, sa);
                chk("mp_B_stable", mp_B, sb);
                chk("mp_N_stable", mp_N, sn);
            end
            if (mp_start) chk("start_when_ready", mp_ready, 1);
        end
    end

    task automatic run(input string tag, input int m, input int e, input int n,
                       input int hold, input int stall);
        int cyc = 0;
        int s0;
        int exp_c = int'(refpow(m, e, n));
        logic [DW-1:0] ev = DW'(e);
        @(negedge clk);
        chk({tag, ".o_ready_idle"}, o_ready, 1);
        i_M = DW'(m); i_E = DW'(e); i_N = DW'(n);
        i_R2 = DW'(((1 << DW) * (1 << DW)) % n);
        i_valid = 1'b1;
        hold_rdy = (stall > 0);
        s0 = starts;
        @(posedge clk);
        #1 i_valid = 1'b0;
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge clk);
                chk({tag, ".no_start_stalled"}, mp_start, 0);
            end
            hold_rdy = 1'b0;
            #1 chk({tag, ".start_on_ready"}, mp_start, 1);
            @(negedge clk);
            chk({tag, ".start_one_cycle"}, mp_start, 0);
        end
        while (!o_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".no_timeout"}, (cyc < 2000), 1);
        chk({tag, ".o_C"}, o_C, exp_c);
        chk({tag, ".starts"}, starts - s0, 3 + DW + $countones(ev));
        repeat (hold) begin
            chk({tag, ".hold_valid"}, o_valid, 1);
            chk({tag, ".hold_o_C"}, o_C, exp_c);
            chk({tag, ".hold_not_ready"}, o_ready, 0);
            @(negedge clk);
        end
        chk({tag, ".o_ready_busy"}, o_ready, 0);
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        chk({tag, ".valid_dropped"}, o_valid, 0);
        chk({tag, ".ready_back"}, o_ready, 1);
    endtask

    initial begin
        int cyc;
        int n, m;
        repeat (3) @(negedge clk);
        chk("rst.o_valid", o_valid, 0);
        chk("rst.mp_start", mp_start, 0);
        chk("rst.o_C", o_C, 0);
        chk("rst.mp_A", mp_A, 0);
        chk("rst.mp_B", mp_B, 0);
        chk("rst.mp_N", mp_N, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.o_ready", o_ready, 1);

        run("m7e3", 7, 3, 143, 0, 0);
        run("m2e0", 2, 0, 143, 0, 0);
        run("m0e5", 0, 5, 143, 0, 0);
        run("m100e1", 100, 1, 143, 0, 0);
        run("hold20", 7, 3, 143, 20, 0);

        // Abort during the fifth outstanding product
        @(negedge clk);
        i_M = 10'd7; i_E = 10'd3; i_N = 10'd143; i_R2 = 10'd100; i_valid = 1'b1;
        cyc = starts;
        @(posedge clk);
        #1 i_valid = 1'b0;
        while (starts - cyc < 5 && starts - cyc >= 0 && !o_valid) @(negedge clk);
        chk("abort.reached_wait5", starts - cyc, 5);
        rst = 1'b1;
        #1;
        chk("abort.o_valid", o_valid, 0);
        chk("abort.mp_start", mp_start, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.o_ready", o_ready, 1);
        chk("abort.o_valid_after", o_valid, 0);
        run("after_abort", 7, 3, 143, 0, 0);

        run("stall7", 7, 3, 143, 0, 7);

        for (int k = 0; k < 8; k++) begin
            n = 2 * $urandom_range(1, 127) + 1;
            m = $urandom_range(0, n - 1);
            run($sformatf("rnd%0d", k), m, $urandom_range(0, (1 << DW) - 1), n,
                $urandom_range(0, 3), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
